pipe5_writeback_stage: RTL and testbench

Final stage of the five-stage pipeline. It consumes the memory/writeback pipeline register and selects the register-file write data. It drives the register-file write port, the writeback-side forwarding inputs and a one-cycle write-hold bypass for decode. It also owns the retired-instruction counter and the halt drain state machine that raises the core's sticky halt.

---
 rtl/pipe5_writeback_stage_pkg.sv | 43 ++++
 rtl/rv32i_types_pkg.sv | 20 ++
 rtl/pipe5_writeback_stage_if.sv | 54 +++++
 rtl/pipe5_wb_halt_fsm.sv | 69 ++++++
 rtl/pipe5_writeback_stage.sv | 131 +++++++++++++
 tb/tb_pipe5_writeback_stage.sv | 155 +++++++++++++++
 6 files changed

// File: rtl/pipe5_writeback_stage_pkg.sv
// Shared pipe5 writeback types: write-source select, halt FSM state and the
// register-file write-data selector.
package pipe5_writeback_stage_pkg;

  localparam int DRAIN_CNT_W = 4;

  typedef enum logic [2:0] {
    W_SRC_ALU  = 3'd0,
    W_SRC_LOAD = 3'd1,
    W_SRC_PC4  = 3'd2,
    W_SRC_IMM  = 3'd3,
    W_SRC_CSR  = 3'd4
  } w_src_t;

  typedef enum logic [1:0] {
    WB_RUN    = 2'd0,
    WB_DRAIN  = 2'd1,
    WB_HALTED = 2'd2
  } wb_state_t;

  // Reserved select codes (5-7) write zero; PC+4 wraps naturally at 32 bits.
  function automatic logic [31:0] wb_select(
    input logic [2:0]  src,
    input logic [31:0] alu,
    input logic [31:0] load,
    input logic [31:0] pc,
    input logic [31:0] imm,
    input logic [31:0] csr
  );
    logic [31:0] res;
    res = 32'd0;
    case (src)
      W_SRC_ALU:  res = alu;
      W_SRC_LOAD: res = load;
      W_SRC_PC4:  res = pc + 32'd4;
      W_SRC_IMM:  res = imm;
      W_SRC_CSR:  res = csr;
      default:    res = 32'd0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/rv32i_types_pkg.sv
// RV32I base opcode encodings shared across the pipe5 core.
// The all-zero encoding marks a pipeline bubble.
package rv32i_types_pkg;

  typedef enum logic [6:0] {
    OPC_NONE     = 7'h00,
    OPC_LOAD     = 7'h03,
    OPC_MISC_MEM = 7'h0F,
    OPC_OP_IMM   = 7'h13,
    OPC_AUIPC    = 7'h17,
    OPC_STORE    = 7'h23,
    OPC_OP       = 7'h33,
    OPC_LUI      = 7'h37,
    OPC_BRANCH   = 7'h63,
    OPC_JALR     = 7'h67,
    OPC_JAL      = 7'h6F,
    OPC_SYSTEM   = 7'h73
  } opcode_t;

endpackage

// File: rtl/pipe5_writeback_stage_if.sv
// Mem/WB register inputs and writeback-stage outputs of the pipe5 core.
// master = pipeline side driving the stage, slave = the writeback stage.
interface pipe5_writeback_stage_if #(
  parameter int CNT_W = 64
);
  import rv32i_types_pkg::*;

  logic             pc_en;
  opcode_t          opcode;
  logic             wen;
  logic [2:0]       w_src;
  logic [31:0]      alu_port_out;
  logic [31:0]      dload_ext;
  logic [31:0]      reg_file_wdata;
  logic [31:0]      csr_rdata;
  logic [4:0]       reg_rd;
  logic [31:0]      pc;
  logic [31:0]      instr;
  logic             halt_instr;

  logic             rf_wen;
  logic [4:0]       rf_rd;
  logic [31:0]      rf_wdata;
  logic [4:0]       bypass_rd_wb;
  logic             bypass_wen_wb;
  logic [31:0]      bypass_data_wb;
  logic             hold_valid;
  logic [4:0]       hold_rd;
  logic [31:0]      hold_data;
  logic [CNT_W-1:0] instret;
  logic             halt;
  logic             trace_valid;
  logic [31:0]      trace_pc;
  logic [31:0]      trace_instr;
  logic [4:0]       trace_rd;
  logic [31:0]      trace_wdata;

  modport master (
    output pc_en, opcode, wen, w_src, alu_port_out, dload_ext, reg_file_wdata,
           csr_rdata, reg_rd, pc, instr, halt_instr,
    input  rf_wen, rf_rd, rf_wdata, bypass_rd_wb, bypass_wen_wb, bypass_data_wb,
           hold_valid, hold_rd, hold_data, instret, halt,
           trace_valid, trace_pc, trace_instr, trace_rd, trace_wdata
  );

  modport slave (
    input  pc_en, opcode, wen, w_src, alu_port_out, dload_ext, reg_file_wdata,
           csr_rdata, reg_rd, pc, instr, halt_instr,
    output rf_wen, rf_rd, rf_wdata, bypass_rd_wb, bypass_wen_wb, bypass_data_wb,
           hold_valid, hold_rd, hold_data, instret, halt,
           trace_valid, trace_pc, trace_instr, trace_rd, trace_wdata
  );

endinterface

// File: rtl/pipe5_wb_halt_fsm.sv
// Halt drain FSM: a retiring halt instruction starts a DRAIN_CYCLES-long drain,
// after which the sticky halt is raised until reset.
module pipe5_wb_halt_fsm
  import pipe5_writeback_stage_pkg::*;
#(
  parameter int DRAIN_CYCLES = 4
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      retire,
  input  logic      halt_instr,
  output wb_state_t state,
  output logic      halt
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD = DRAIN_CNT_W'(DRAIN_CYCLES - 1);

  logic [1:0]             state_q, state_d;
  logic [DRAIN_CNT_W-1:0] cnt_q, cnt_d;
  logic                   halt_q, halt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (retire && halt_instr) begin
          state_d = ST_DRAIN;
          cnt_d   = DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == '0) begin
          state_d = ST_HALTED;
        end else begin
          cnt_d = cnt_q - DRAIN_CNT_W'(1);
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
    // Halt is registered from the next state so it rises on the HALTED entry edge.
    halt_d = (state_d == ST_HALTED);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      halt_q  <= halt_d;
    end
  end

  assign state = wb_state_t'(state_q);
  assign halt  = halt_q;

endmodule

// File: rtl/pipe5_writeback_stage.sv
// pipe5 writeback stage: register-file write, forwarding, write-hold bypass,
// retired-instruction counter and halt drain. Retire trace: WB_RETIRE_TRACE_EN.
module pipe5_writeback_stage
  import pipe5_writeback_stage_pkg::*;
  import rv32i_types_pkg::*;
#(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 64
) (
  input  logic                  CLK,
  input  logic                  RST,
  pipe5_writeback_stage_if.slave wb
);

  wb_state_t   state;
  logic        halt_q;
  logic        valid;
  logic        in_run;
  logic        retire;
  logic        wr_ok;
  logic        rf_wen;
  logic [31:0] wdata;

  logic             hold_valid_q, hold_valid_d;
  logic [4:0]       hold_rd_q, hold_rd_d;
  logic [31:0]      hold_data_q, hold_data_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  // Forwarding ignores pc_en so decode still sees WB data while stalled.
  always_comb begin
    valid  = (wb.opcode != OPC_NONE);
    in_run = (state == WB_RUN);
    retire = valid & wb.pc_en & in_run;
    wr_ok  = valid & in_run & wb.wen & (wb.reg_rd != 5'd0) & ~wb.halt_instr;
    rf_wen = wr_ok & wb.pc_en;
    wdata  = wb_select(wb.w_src, wb.alu_port_out, wb.dload_ext, wb.pc,
                       wb.reg_file_wdata, wb.csr_rdata);
  end

  always_comb begin
    hold_valid_d = rf_wen;
    hold_rd_d    = rf_wen ? wb.reg_rd : hold_rd_q;
    hold_data_d  = rf_wen ? wdata : hold_data_q;
    instret_d    = (retire && !wb.halt_instr) ? instret_q + CNT_W'(1) : instret_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      hold_valid_q <= 1'b0;
      hold_rd_q    <= 5'd0;
      hold_data_q  <= 32'd0;
      instret_q    <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_rd_q    <= hold_rd_d;
      hold_data_q  <= hold_data_d;
      instret_q    <= instret_d;
    end
  end

  pipe5_wb_halt_fsm #(
    .DRAIN_CYCLES (DRAIN_CYCLES)
  ) u_halt_fsm (
    .CLK        (CLK),
    .RST        (RST),
    .retire     (retire),
    .halt_instr (wb.halt_instr),
    .state      (state),
    .halt       (halt_q)
  );

  assign wb.rf_wen         = rf_wen;
  assign wb.rf_rd          = wb.reg_rd;
  assign wb.rf_wdata       = wdata;
  assign wb.bypass_rd_wb   = wb.reg_rd;
  assign wb.bypass_wen_wb  = wr_ok;
  assign wb.bypass_data_wb = wdata;
  assign wb.hold_valid     = hold_valid_q;
  assign wb.hold_rd        = hold_rd_q;
  assign wb.hold_data      = hold_data_q;
  assign wb.instret        = instret_q;
  assign wb.halt           = halt_q;

`ifdef WB_RETIRE_TRACE_EN
  logic        trace_valid_q, trace_valid_d;
  logic [31:0] trace_pc_q, trace_pc_d;
  logic [31:0] trace_instr_q, trace_instr_d;
  logic [4:0]  trace_rd_q, trace_rd_d;
  logic [31:0] trace_wdata_q, trace_wdata_d;

  // Every retire is traced, the halt marker included; rd/wdata read 0 without a write.
  always_comb begin
    trace_valid_d = retire;
    trace_pc_d    = retire ? wb.pc : trace_pc_q;
    trace_instr_d = retire ? wb.instr : trace_instr_q;
    trace_rd_d    = retire ? (rf_wen ? wb.reg_rd : 5'd0) : trace_rd_q;
    trace_wdata_d = retire ? (rf_wen ? wdata : 32'd0) : trace_wdata_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      trace_valid_q <= 1'b0;
      trace_pc_q    <= 32'd0;
      trace_instr_q <= 32'd0;
      trace_rd_q    <= 5'd0;
      trace_wdata_q <= 32'd0;
    end else begin
      trace_valid_q <= trace_valid_d;
      trace_pc_q    <= trace_pc_d;
      trace_instr_q <= trace_instr_d;
      trace_rd_q    <= trace_rd_d;
      trace_wdata_q <= trace_wdata_d;
    end
  end

  assign wb.trace_valid = trace_valid_q;
  assign wb.trace_pc    = trace_pc_q;
  assign wb.trace_instr = trace_instr_q;
  assign wb.trace_rd    = trace_rd_q;
  assign wb.trace_wdata = trace_wdata_q;
`else
  logic trace_unused;
  assign trace_unused   = ^wb.instr;
  assign wb.trace_valid = 1'b0;
  assign wb.trace_pc    = 32'd0;
  assign wb.trace_instr = 32'd0;
  assign wb.trace_rd    = 5'd0;
  assign wb.trace_wdata = 32'd0;
`endif

endmodule

// File: tb/tb_pipe5_writeback_stage.sv
// Scoreboard bench for pipe5_writeback_stage: directed vectors push hand-computed
// expectations, a negedge monitor pops and compares them.
module tb_pipe5_writeback_stage;
  import rv32i_types_pkg::*;

  typedef struct {
    bit          rf_wen;
    logic [4:0]  rd;
    logic [31:0] wdata;
    bit          bwen;
    bit          hv;
    logic [4:0]  hrd;
    logic [31:0] hd;
    logic [63:0] ir;
    bit          halt;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    compared   = 0;
  int    mismatched = 0;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  exp_t  mon_e;
  string mon_n;

  always #5 clk = ~clk;

  pipe5_writeback_stage_if #(.CNT_W(64)) bus ();

  pipe5_writeback_stage #(
    .DRAIN_CYCLES (4),
    .CNT_W        (64)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .wb  (bus)
  );

  task automatic checkOutput(input string name, input string field,
                             input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s %s: got 0x%0h, expected 0x%0h", name, field, act, exp);
    end
  endtask

  task automatic applyStimulus(
    input string name, input bit r, input bit en, input logic [6:0] op,
    input bit w, input logic [2:0] src, input logic [4:0] rd, input logic [31:0] pc,
    input bit hi,
    input bit e_wen, input logic [31:0] e_wdata, input bit e_bwen,
    input bit e_hv, input logic [4:0] e_hrd, input logic [31:0] e_hd,
    input logic [63:0] e_ir, input bit e_halt
  );
    exp_t e;
    @(posedge clk);
    #1;
    rst            = r;
    bus.pc_en      = en;
    bus.opcode     = opcode_t'(op);
    bus.wen        = w;
    bus.w_src      = src;
    bus.reg_rd     = rd;
    bus.pc         = pc;
    bus.instr      = pc ^ 32'h1357_9BDF;
    bus.halt_instr = hi;
    e = '{e_wen, rd, e_wdata, e_bwen, e_hv, e_hrd, e_hd, e_ir, e_halt};
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  // Monitor: compares the oldest expectation mid-cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        mon_n = name_q.pop_front();
        checkOutput(mon_n, "rf_wen",         64'(bus.rf_wen),         64'(mon_e.rf_wen));
        checkOutput(mon_n, "rf_rd",          64'(bus.rf_rd),          64'(mon_e.rd));
        checkOutput(mon_n, "rf_wdata",       64'(bus.rf_wdata),       64'(mon_e.wdata));
        checkOutput(mon_n, "bypass_wen_wb",  64'(bus.bypass_wen_wb),  64'(mon_e.bwen));
        checkOutput(mon_n, "bypass_rd_wb",   64'(bus.bypass_rd_wb),   64'(mon_e.rd));
        checkOutput(mon_n, "bypass_data_wb", 64'(bus.bypass_data_wb), 64'(mon_e.wdata));
        checkOutput(mon_n, "hold_valid",     64'(bus.hold_valid),     64'(mon_e.hv));
        checkOutput(mon_n, "hold_rd",        64'(bus.hold_rd),        64'(mon_e.hrd));
        checkOutput(mon_n, "hold_data",      64'(bus.hold_data),      64'(mon_e.hd));
        checkOutput(mon_n, "instret",        bus.instret,             mon_e.ir);
        checkOutput(mon_n, "halt",           64'(bus.halt),           64'(mon_e.halt));
`ifndef WB_RETIRE_TRACE_EN
        checkOutput(mon_n, "trace_valid",    64'(bus.trace_valid),    64'd0);
        checkOutput(mon_n, "trace_wdata",    64'(bus.trace_wdata),    64'd0);
`endif
      end
    end
  end

  initial begin
    bus.pc_en          = 1'b0;
    bus.opcode         = OPC_NONE;
    bus.wen            = 1'b0;
    bus.w_src          = 3'd0;
    bus.alu_port_out   = 32'h0000_1234;
    bus.dload_ext      = 32'h0000_00AB;
    bus.reg_file_wdata = 32'h5000_0000;
    bus.csr_rdata      = 32'hC5C5_0001;
    bus.reg_rd         = 5'd0;
    bus.pc             = 32'd0;
    bus.instr          = 32'd0;
    bus.halt_instr     = 1'b0;
    rst                = 1'b1;
    repeat (2) @(posedge clk);

    //            name                 rst en op     w src rd  pc            hi  wen wdata         bwen hv hrd hd            ir halt
    applyStimulus("reset_state",       0, 1, 7'h00, 0, 0, 0,  32'h0,        0,  0, 32'h1234,     0,   0, 0,  32'h0,        0, 0);
    applyStimulus("alu_write",         0, 1, 7'h33, 1, 0, 5,  32'h10,       0,  1, 32'h1234,     1,   0, 0,  32'h0,        0, 0);
    applyStimulus("x0_write",          0, 1, 7'h33, 1, 1, 0,  32'h14,       0,  0, 32'hAB,       0,   1, 5,  32'h1234,     1, 0);
    applyStimulus("bubble",            0, 1, 7'h00, 1, 0, 7,  32'h18,       0,  0, 32'h1234,     0,   0, 5,  32'h1234,     2, 0);
    applyStimulus("pc4_wrap",          0, 1, 7'h6F, 1, 2, 1,  32'hFFFFFFFC, 0,  1, 32'h0,        1,   0, 5,  32'h1234,     2, 0);
    applyStimulus("pc4",               0, 1, 7'h6F, 1, 2, 2,  32'h100,      0,  1, 32'h104,      1,   1, 1,  32'h0,        3, 0);
    applyStimulus("imm",               0, 1, 7'h37, 1, 3, 3,  32'h108,      0,  1, 32'h50000000, 1,   1, 2,  32'h104,      4, 0);
    applyStimulus("csr",               0, 1, 7'h73, 1, 4, 4,  32'h10C,      0,  1, 32'hC5C50001, 1,   1, 3,  32'h50000000, 5, 0);
    applyStimulus("reserved_src",      0, 1, 7'h33, 1, 5, 6,  32'h110,      0,  1, 32'h0,        1,   1, 4,  32'hC5C50001, 6, 0);
    applyStimulus("stall",             0, 0, 7'h03, 1, 1, 8,  32'h114,      0,  0, 32'hAB,       1,   1, 6,  32'h0,        7, 0);
    applyStimulus("stall_release",     0, 1, 7'h03, 1, 1, 8,  32'h114,      0,  1, 32'hAB,       1,   0, 6,  32'h0,        7, 0);
    applyStimulus("halt_retire",       0, 1, 7'h73, 1, 0, 9,  32'h118,      1,  0, 32'h1234,     0,   1, 8,  32'hAB,       8, 0);
    applyStimulus("drain_write",       0, 1, 7'h33, 1, 0, 10, 32'h11C,      0,  0, 32'h1234,     0,   0, 8,  32'hAB,       8, 0);
    for (int i = 0; i < 3; i++)
      applyStimulus("drain_idle",      0, 1, 7'h00, 0, 0, 0,  32'h0,        0,  0, 32'h1234,     0,   0, 8,  32'hAB,       8, 0);
    applyStimulus("halted_write",      0, 1, 7'h33, 1, 0, 11, 32'h120,      0,  0, 32'h1234,     0,   0, 8,  32'hAB,       8, 1);
    applyStimulus("halted_idle",       0, 1, 7'h00, 0, 0, 0,  32'h0,        0,  0, 32'h1234,     0,   0, 8,  32'hAB,       8, 1);
    applyStimulus("reset_from_halt",   1, 1, 7'h00, 0, 0, 0,  32'h0,        0,  0, 32'h1234,     0,   0, 8,  32'hAB,       8, 1);
    applyStimulus("after_reset",       0, 1, 7'h00, 0, 0, 0,  32'h0,        0,  0, 32'h1234,     0,   0, 0,  32'h0,        0, 0);
    applyStimulus("halt_again",        0, 1, 7'h73, 0, 0, 0,  32'h200,      1,  0, 32'h1234,     0,   0, 0,  32'h0,        0, 0);
    applyStimulus("drain_cycle1",      0, 1, 7'h00, 0, 0, 0,  32'h0,        0,  0, 32'h1234,     0,   0, 0,  32'h0,        0, 0);
    applyStimulus("reset_mid_drain",   1, 1, 7'h33, 1, 0, 12, 32'h204,      0,  0, 32'h1234,     0,   0, 0,  32'h0,        0, 0);
    applyStimulus("retire_after_rst",  0, 1, 7'h33, 1, 0, 13, 32'h208,      0,  1, 32'h1234,     1,   0, 0,  32'h0,        0, 0);
    applyStimulus("count_after_rst",   0, 1, 7'h00, 0, 0, 0,  32'h0,        0,  0, 32'h1234,     0,   1, 13, 32'h1234,     1, 0);
    for (int i = 0; i < 5; i++)
      applyStimulus("aborted_drain",   0, 1, 7'h00, 0, 0, 0,  32'h0,        0,  0, 32'h1234,     0,   0, 13, 32'h1234,     1, 0);

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
